// File: rtl/note_sched_if.sv
// note_sched_if: chart ROM read port plus per-lane spawn handshake.
// master = scheduler side, slave = ROM / arrow_logic side.
interface note_sched_if #(
  parameter int CHART_AW = 8
) ();
  logic [CHART_AW-1:0] chart_addr;
  logic                chart_rd;
  logic [7:0]          chart_data;
  logic [3:0]          spawn_valid;
  logic [3:0]          spawn_ready;

  modport master (
    output chart_addr,
    output chart_rd,
    output spawn_valid,
    input  chart_data,
    input  spawn_ready
  );

  modport slave (
    input  chart_addr,
    input  chart_rd,
    input  spawn_valid,
    output chart_data,
    output spawn_ready
  );
endinterface

// File: rtl/note_scheduler.sv
// note_scheduler: walks the step chart ROM and issues per-lane spawns.
// Define NOTE_SCHED_LOOP_EN to replay the chart forever instead of DONE.
module note_scheduler #(
  parameter int CHART_AW  = 8,
  parameter int GAP_SHIFT = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         frame_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         pause_i,
  note_sched_if.master bus,
  output logic         busy_o,
  output logic         done_o,
  output logic [7:0]   drop_cnt_o
);
  localparam int CW = 4 + GAP_SHIFT;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_DATA, ISSUE, COUNT, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CHART_AW-1:0] addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [3:0]          valid_q, valid_d;
  logic [3:0]          gap_q, gap_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          drop_q, drop_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          pend;
  logic [2:0]          npend;
  logic [8:0]          drop_sum;
  logic [7:0]          drop_sat;
  logic                at_end;

`ifdef NOTE_SCHED_LOOP_EN
  assign at_end = 1'b0;
`else
  assign at_end = &addr_q;
`endif

  // lanes still unserved after this cycle's handshakes
  assign pend     = valid_q & ~bus.spawn_ready;
  assign npend    = {2'b0, pend[0]} + {2'b0, pend[1]}
                  + {2'b0, pend[2]} + {2'b0, pend[3]};
  assign drop_sum = {1'b0, drop_q} + {6'b0, npend};
  assign drop_sat = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          addr_d  = '0;
          drop_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT_DATA;
      WAIT_DATA: begin
        gap_d = bus.chart_data[7:4];
        if (bus.chart_data == 8'h00) begin
`ifdef NOTE_SCHED_LOOP_EN
          addr_d  = '0;
          state_d = FETCH;
`else
          state_d = DONE;
`endif
        end else if (bus.chart_data[3:0] == 4'h0) begin
          cnt_d   = CW'(bus.chart_data[7:4]) << GAP_SHIFT;
          addr_d  = at_end ? addr_q : addr_q + CHART_AW'(1);
          state_d = at_end ? DONE : COUNT;
        end else begin
          valid_d = bus.chart_data[3:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        valid_d = pend;
        if (pend == 4'h0 || frame_i) begin
          valid_d = '0;
          drop_d  = drop_sat;
          cnt_d   = CW'(gap_q) << GAP_SHIFT;
          addr_d  = at_end ? addr_q : addr_q + CHART_AW'(1);
          if (at_end)             state_d = DONE;
          else if (gap_q == 4'h0) state_d = FETCH;
          else                    state_d = COUNT;
        end
      end
      COUNT: begin
        if (frame_i && !pause_i) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (stop_i) begin
      state_d = IDLE;
      valid_d = '0;
      addr_d  = addr_q;
      drop_d  = drop_q;
    end
    rd_d   = (state_d == FETCH);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      valid_q <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.chart_addr  = addr_q;
  assign bus.chart_rd    = rd_q;
  assign bus.spawn_valid = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign drop_cnt_o      = drop_q;
endmodule
